hazard_unit: RTL and testbench

- Hazard/interlock block for the 5-stage MIPS pipeline; the consumer of the per-stage control bits (branchD, regwriteE/M/W, memtoregE/M) and the producer of flushE plus all stall/forward controls.
- Combinational part: operand forwarding, load-use and branch-compare interlocks.
- Sequential part: a start/done handshake FSM for the multi-cycle mult/div unit; a data-memory wait freeze with pending-done capture; a saturating stall-cycle counter for performance monitoring.

---
 rtl/hazard_unit_pkg.sv | 12 +
 rtl/hazard_unit_md_handshake.sv | 43 ++++
 rtl/hazard_unit.sv | 110 +++++++++++
 tb/tb_hazard_unit.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/hazard_unit_pkg.sv
// Shared encodings for the hazard unit: forward-select codes and mult/div
// handshake FSM states.
package hazard_unit_pkg;

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_W  = 2'b01;
  localparam logic [1:0] FWD_M  = 2'b10;

  localparam logic [0:0] MD_IDLE = 1'b0;
  localparam logic [0:0] MD_BUSY = 1'b1;

endpackage

// File: rtl/hazard_unit_md_handshake.sv
// Start/done handshake with the multi-cycle mult/div unit. A done pulse that
// lands during a memory freeze is held in donePend until the freeze lifts.
module md_handshake
  import hazard_unit_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic mdopE,
  input  logic md_done,
  input  logic frozen,
  output logic mdstall,
  output logic md_start,
  output logic md_busy
);

  logic [0:0] state;
  logic       donePend;
  logic       mdRelease;

  assign mdRelease = md_done || donePend;
  assign md_busy   = (state == MD_BUSY);
  assign mdstall   = ((state == MD_IDLE) && mdopE) ||
                     ((state == MD_BUSY) && !mdRelease);
  assign md_start  = !rst && !frozen && (state == MD_IDLE) && mdopE;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= MD_IDLE;
      donePend <= 1'b0;
    end else if (state == MD_IDLE) begin
      // done in IDLE is a protocol error and is dropped
      if (mdopE && !frozen) state <= MD_BUSY;
    end else begin
      if (!frozen && mdRelease) begin
        state    <= MD_IDLE;
        donePend <= 1'b0;
      end else if (md_done) begin
        donePend <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/hazard_unit.sv
// Hazard/interlock unit for the 5-stage MIPS pipeline: forwarding selects,
// load-use/branch/mult-div interlocks, memory-wait freeze and stall counter.
module hazard_unit
  import hazard_unit_pkg::*;
#(
  parameter int CNT_W = 32,
  parameter int REG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] rsD,
  input  logic [REG_W-1:0] rtD,
  input  logic [REG_W-1:0] rsE,
  input  logic [REG_W-1:0] rtE,
  input  logic [REG_W-1:0] writeregE,
  input  logic [REG_W-1:0] writeregM,
  input  logic [REG_W-1:0] writeregW,
  input  logic             regwriteE,
  input  logic             regwriteM,
  input  logic             regwriteW,
  input  logic             memtoregE,
  input  logic             memtoregM,
  input  logic             branchD,
  input  logic             mdopE,
  input  logic             md_done,
  input  logic             mem_stallM,
  output logic             forwardaD,
  output logic             forwardbD,
  output logic [1:0]       forwardaE,
  output logic [1:0]       forwardbE,
  output logic             stallF,
  output logic             stallD,
  output logic             stallE,
  output logic             stallM,
  output logic             flushE,
  output logic             flushM,
  output logic             md_start,
  output logic             md_busy,
  output logic [CNT_W-1:0] stall_cnt
);

  // Register 0 is hardwired, so it never produces a dependency.
  function automatic logic hits(input logic [REG_W-1:0] dst,
                                input logic [REG_W-1:0] src);
    return (dst == src) && (src != '0);
  endfunction

  logic lwstall;
  logic brstall;
  logic mdstall;

  md_handshake uMd (
    .clk      (clk),
    .rst      (rst),
    .mdopE    (mdopE),
    .md_done  (md_done),
    .frozen   (mem_stallM),
    .mdstall  (mdstall),
    .md_start (md_start),
    .md_busy  (md_busy)
  );

  always_comb begin
    forwardaE = FWD_RF;
    if (regwriteM && hits(writeregM, rsE))      forwardaE = FWD_M;
    else if (regwriteW && hits(writeregW, rsE)) forwardaE = FWD_W;

    forwardbE = FWD_RF;
    if (regwriteM && hits(writeregM, rtE))      forwardbE = FWD_M;
    else if (regwriteW && hits(writeregW, rtE)) forwardbE = FWD_W;
  end

  assign forwardaD = regwriteM && hits(writeregM, rsD);
  assign forwardbD = regwriteM && hits(writeregM, rtD);

  assign lwstall = memtoregE && (hits(rtE, rsD) || hits(rtE, rtD));
  assign brstall = branchD &&
                   ((regwriteE && (hits(writeregE, rsD) || hits(writeregE, rtD))) ||
                    (memtoregM && (hits(writeregM, rsD) || hits(writeregM, rtD))));

  always_comb begin
    stallF = 1'b0;
    stallD = 1'b0;
    stallE = 1'b0;
    stallM = 1'b0;
    flushE = 1'b0;
    flushM = 1'b0;
    if (mem_stallM) begin
      stallF = 1'b1;
      stallD = 1'b1;
      stallE = 1'b1;
      stallM = 1'b1;
    end else begin
      stallF = lwstall || brstall || mdstall;
      stallD = stallF;
      stallE = mdstall;
      flushE = (lwstall || brstall) && !mdstall;
      flushM = mdstall;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (stallF && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_unit.sv
// Directed bench for hazard_unit: expected controls are queued as each step is
// driven and popped against the DUT outputs a moment later.
module tb_hazard_unit;
  localparam int CNT_W = 6;
  localparam int REG_W = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst;
  logic [REG_W-1:0] rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW;
  logic             regwriteE, regwriteM, regwriteW, memtoregE, memtoregM;
  logic             branchD, mdopE, md_done, mem_stallM;
  logic             forwardaD, forwardbD;
  logic [1:0]       forwardaE, forwardbE;
  logic             stallF, stallD, stallE, stallM, flushE, flushM;
  logic             md_start, md_busy;
  logic [CNT_W-1:0] stall_cnt;

  hazard_unit #(.CNT_W(CNT_W), .REG_W(REG_W)) dut (
    .clk(clk), .rst(rst),
    .rsD(rsD), .rtD(rtD), .rsE(rsE), .rtE(rtE),
    .writeregE(writeregE), .writeregM(writeregM), .writeregW(writeregW),
    .regwriteE(regwriteE), .regwriteM(regwriteM), .regwriteW(regwriteW),
    .memtoregE(memtoregE), .memtoregM(memtoregM),
    .branchD(branchD), .mdopE(mdopE), .md_done(md_done), .mem_stallM(mem_stallM),
    .forwardaD(forwardaD), .forwardbD(forwardbD),
    .forwardaE(forwardaE), .forwardbE(forwardbE),
    .stallF(stallF), .stallD(stallD), .stallE(stallE), .stallM(stallM),
    .flushE(flushE), .flushM(flushM),
    .md_start(md_start), .md_busy(md_busy), .stall_cnt(stall_cnt)
  );

  typedef struct {
    string            tag;
    logic [13:0]      ctl;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  exp_t             sb[$];
  int               vectors = 0;
  int               miscompares = 0;
  logic [CNT_W-1:0] expCnt = '0;

  task automatic clr();
    rsD = '0; rtD = '0; rsE = '0; rtE = '0;
    writeregE = '0; writeregM = '0; writeregW = '0;
    regwriteE = 1'b0; regwriteM = 1'b0; regwriteW = 1'b0;
    memtoregE = 1'b0; memtoregM = 1'b0; branchD = 1'b0;
    mdopE = 1'b0; md_done = 1'b0; mem_stallM = 1'b0;
  endtask

  // stl = {stallF,stallD,stallE,stallM}, fl = {flushE,flushM}
  task automatic step(input string tag, input logic [1:0] fa, input logic [1:0] fb,
                      input logic fad, input logic fbd, input logic [3:0] stl,
                      input logic [1:0] fl, input logic st, input logic bz);
    exp_t        e;
    exp_t        got;
    logic [13:0] obs;
    e.tag = tag;
    e.ctl = {fa, fb, fad, fbd, stl, fl, st, bz};
    e.cnt = expCnt;
    sb.push_back(e);
    #1;
    got = sb.pop_front();
    obs = {forwardaE, forwardbE, forwardaD, forwardbD, stallF, stallD, stallE,
           stallM, flushE, flushM, md_start, md_busy};
    vectors++;
    assert (obs === got.ctl) else begin
      miscompares++;
      $error("FAIL %s ctl observed=%b expected=%b", got.tag, obs, got.ctl);
    end
    vectors++;
    assert (stall_cnt === got.cnt) else begin
      miscompares++;
      $error("FAIL %s stall_cnt observed=%0d expected=%0d", got.tag, stall_cnt, got.cnt);
    end
    @(posedge clk);
    if (rst) expCnt = '0;
    else if (stl[3] && (expCnt != '1)) expCnt = expCnt + 1'b1;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    clr();
    repeat (2) @(posedge clk);
    @(negedge clk);
    step("reset", 2'b00, 2'b00, 0, 0, 4'b0000, 2'b00, 0, 0);
    rst = 1'b0;

    // forwarding priority and register-0 exclusion
    regwriteM = 1'b1; writeregM = 5'd8; rsE = 5'd8; regwriteW = 1'b1; writeregW = 5'd8;
    step("fwdM", 2'b10, 2'b00, 0, 0, 4'b0000, 2'b00, 0, 0);
    regwriteM = 1'b0;
    step("fwdW", 2'b01, 2'b00, 0, 0, 4'b0000, 2'b00, 0, 0);
    regwriteM = 1'b1; rsE = '0; writeregM = '0; writeregW = '0;
    step("fwdR0", 2'b00, 2'b00, 0, 0, 4'b0000, 2'b00, 0, 0);
    rtE = 5'd5; writeregM = 5'd5; writeregW = 5'd5;
    step("fwdbM", 2'b00, 2'b10, 0, 0, 4'b0000, 2'b00, 0, 0);

    // load-use interlock
    clr(); memtoregE = 1'b1; rtE = 5'd9; rsD = 5'd9;
    step("lduse", 2'b00, 2'b00, 0, 0, 4'b1100, 2'b10, 0, 0);
    memtoregE = 1'b0;
    step("lduseOff", 2'b00, 2'b00, 0, 0, 4'b0000, 2'b00, 0, 0);
    clr(); memtoregE = 1'b1;
    step("lduseR0", 2'b00, 2'b00, 0, 0, 4'b0000, 2'b00, 0, 0);

    // branch-compare interlocks
    clr(); branchD = 1'b1; memtoregM = 1'b1; regwriteM = 1'b1; writeregM = 5'd4; rtD = 5'd4;
    step("brM", 2'b00, 2'b00, 0, 1, 4'b1100, 2'b10, 0, 0);
    memtoregM = 1'b0;
    step("brFwd", 2'b00, 2'b00, 0, 1, 4'b0000, 2'b00, 0, 0);
    clr(); branchD = 1'b1; regwriteE = 1'b1; writeregE = 5'd3; rsD = 5'd3;
    step("brE", 2'b00, 2'b00, 0, 0, 4'b1100, 2'b10, 0, 0);
    writeregE = '0; rsD = '0;
    step("brR0", 2'b00, 2'b00, 0, 0, 4'b0000, 2'b00, 0, 0);

    // mult/div handshake with a 33-cycle stall window
    clr(); mdopE = 1'b1;
    step("mdStart", 2'b00, 2'b00, 0, 0, 4'b1110, 2'b01, 1, 0);
    for (int i = 0; i < 32; i++)
      step("mdBusy", 2'b00, 2'b00, 0, 0, 4'b1110, 2'b01, 0, 1);
    md_done = 1'b1;
    step("mdDone", 2'b00, 2'b00, 0, 0, 4'b0000, 2'b00, 0, 1);
    md_done = 1'b0;
    step("b2bStart", 2'b00, 2'b00, 0, 0, 4'b1110, 2'b01, 1, 0);

    // done captured during a memory freeze
    mem_stallM = 1'b1; md_done = 1'b1;
    step("frzDone", 2'b00, 2'b00, 0, 0, 4'b1111, 2'b00, 0, 1);
    md_done = 1'b0;
    step("frzHold", 2'b00, 2'b00, 0, 0, 4'b1111, 2'b00, 0, 1);
    mem_stallM = 1'b0;
    step("frzRel", 2'b00, 2'b00, 0, 0, 4'b0000, 2'b00, 0, 1);

    // start deferred while frozen, then counter saturation
    mem_stallM = 1'b1;
    step("frzIdle", 2'b00, 2'b00, 0, 0, 4'b1111, 2'b00, 0, 0);
    mem_stallM = 1'b0;
    step("startAfterFrz", 2'b00, 2'b00, 0, 0, 4'b1110, 2'b01, 1, 0);
    mem_stallM = 1'b1;
    for (int i = 0; i < 30; i++)
      step("satFrz", 2'b00, 2'b00, 0, 0, 4'b1111, 2'b00, 0, 1);

    // reset while BUSY, late done ignored
    rst = 1'b1; mem_stallM = 1'b0; mdopE = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    expCnt = '0;
    md_done = 1'b1;
    step("lateDone", 2'b00, 2'b00, 0, 0, 4'b0000, 2'b00, 0, 0);
    md_done = 1'b0; mdopE = 1'b1;
    step("afterLate", 2'b00, 2'b00, 0, 0, 4'b1110, 2'b01, 1, 0);
    step("noPend", 2'b00, 2'b00, 0, 0, 4'b1110, 2'b01, 0, 1);
    md_done = 1'b1;
    step("finDone", 2'b00, 2'b00, 0, 0, 4'b0000, 2'b00, 0, 1);
    clr();
    step("idleEnd", 2'b00, 2'b00, 0, 0, 4'b0000, 2'b00, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
